// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared CDB types and sizing for the broadcast arbiter, RS, ROB and PRF.
package cdb_broadcast_arbiter_pkg;

  localparam int unsigned PHYS_REGS = 128;
  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned CDB_WIDTH = 2;
  localparam int unsigned FU_NUM    = 8;
  localparam int unsigned XLEN      = 32;

  localparam int unsigned PR_W   = $clog2(PHYS_REGS);
  localparam int unsigned ROB_W  = $clog2(ROB_DEPTH);
  localparam int unsigned FU_W   = $clog2(FU_NUM);
  localparam int unsigned LANE_W = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
  localparam int unsigned CNT_W  = $clog2(CDB_WIDTH + 1);

  typedef struct packed {
    logic [PR_W-1:0]  tag;
    logic [ROB_W-1:0] rob_idx;
    logic [XLEN-1:0]  value;
  } fu_complete_t;

  typedef struct packed {
    logic             valid;
    logic [PR_W-1:0]  tag;
    logic [ROB_W-1:0] rob_idx;
    logic [XLEN-1:0]  value;
  } cdb_packet_t;

  // Round-robin successor of an FU index, wrapping at FU_NUM.
  function automatic logic [FU_W-1:0] fu_next(input logic [FU_W-1:0] idx);
    logic [31:0] nxt;
    nxt = 32'(idx) + 32'd1;
    return (nxt >= FU_NUM) ? '0 : FU_W'(nxt);
  endfunction

endpackage

// File: rtl/cdb_broadcast_arbiter_rr_picker.sv
// Combinational multi-grant round-robin picker: first CDB_WIDTH requesters
// starting at ptr win, lane order follows scan order.
module cdb_broadcast_arbiter_rr_picker
  import cdb_broadcast_arbiter_pkg::*;
(
  input  logic [FU_NUM-1:0]               req,
  input  logic [FU_W-1:0]                 ptr,
  output logic [FU_NUM-1:0]               grant,
  output logic [CDB_WIDTH-1:0][FU_W-1:0]  lane_sel,
  output logic [CDB_WIDTH-1:0]            lane_v,
  output logic [FU_W-1:0]                 last_idx
);

  logic [31:0]      pos;
  logic [FU_W-1:0]  idx;
  logic [CNT_W-1:0] cnt;

  // Scan from ptr with wrap, handing winners to lanes in order.
  always_comb begin
    grant    = '0;
    lane_sel = '0;
    lane_v   = '0;
    last_idx = ptr;
    cnt      = '0;
    pos      = '0;
    idx      = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      pos = 32'(ptr) + 32'(i);
      if (pos >= FU_NUM) pos = pos - FU_NUM;
      idx = FU_W'(pos);
      if (req[idx] && (32'(cnt) < CDB_WIDTH)) begin
        grant[idx]                = 1'b1;
        lane_sel[LANE_W'(cnt)]    = idx;
        lane_v[LANE_W'(cnt)]      = 1'b1;
        last_idx                  = idx;
        cnt                       = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// CDB transmit arbiter: one-entry hold per FU, round-robin selection of up to
// CDB_WIDTH completions per cycle, registered broadcast lanes.
// Optional same-cycle bypass of an idle FU's completion: define CDB_BYPASS_EN.
module cdb_broadcast_arbiter
  import cdb_broadcast_arbiter_pkg::*;
(
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [FU_NUM-1:0]                  fu_valid_i,
  input  logic [FU_NUM-1:0][PR_W-1:0]        fu_tag_i,
  input  logic [FU_NUM-1:0][ROB_W-1:0]       fu_rob_idx_i,
  input  logic [FU_NUM-1:0][XLEN-1:0]        fu_value_i,
  output logic [FU_NUM-1:0]                  fu_ready_o,
  output logic [CDB_WIDTH-1:0]               cdb_valid_o,
  output logic [CDB_WIDTH-1:0][PR_W-1:0]     cdb_tag_o,
  output logic [CDB_WIDTH-1:0][ROB_W-1:0]    cdb_rob_idx_o,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]     cdb_value_o
);

  logic [FU_NUM-1:0]                 hold_v, hold_v_d;
  fu_complete_t [FU_NUM-1:0]         hold_q, hold_q_d;
  logic [FU_W-1:0]                   rr_ptr, rr_ptr_d;
  cdb_packet_t [CDB_WIDTH-1:0]       cdb_q, cdb_d;

  fu_complete_t [FU_NUM-1:0]         in_pay, cand;
  logic [FU_NUM-1:0]                 req, grant, accept, bypass_hit;
  logic [CDB_WIDTH-1:0][FU_W-1:0]    lane_sel;
  logic [CDB_WIDTH-1:0]              lane_v;
  logic [FU_W-1:0]                   last_idx;

  // Arbitration candidates: held entry if present, else the live FU payload.
  always_comb begin
    for (int k = 0; k < FU_NUM; k++) begin
      in_pay[k] = '{tag: fu_tag_i[k], rob_idx: fu_rob_idx_i[k], value: fu_value_i[k]};
      cand[k]   = hold_v[k] ? hold_q[k] : in_pay[k];
    end
`ifdef CDB_BYPASS_EN
    req = hold_v | fu_valid_i;
`else
    req = hold_v;
`endif
  end

  cdb_broadcast_arbiter_rr_picker u_picker (
    .req      (req),
    .ptr      (rr_ptr),
    .grant    (grant),
    .lane_sel (lane_sel),
    .lane_v   (lane_v),
    .last_idx (last_idx)
  );

  // A hold can take a new completion when empty or draining this cycle.
  assign fu_ready_o = (reset || flush) ? '0 : (~hold_v | grant);
  assign accept     = fu_valid_i & fu_ready_o;
  // Grant on an empty hold only happens for a bypassed live completion.
  assign bypass_hit = ~hold_v & grant;

  // Next-state for holds, broadcast lanes and round-robin pointer.
  always_comb begin
    hold_v_d = hold_v;
    hold_q_d = hold_q;
    rr_ptr_d = rr_ptr;
    cdb_d    = '0;
    if (reset) begin
      hold_v_d = '0;
      hold_q_d = '0;
      rr_ptr_d = '0;
    end else if (flush) begin
      hold_v_d = '0;
    end else begin
      for (int l = 0; l < CDB_WIDTH; l++) begin
        if (lane_v[l]) begin
          cdb_d[l] = '{valid:   1'b1,
                       tag:     cand[lane_sel[l]].tag,
                       rob_idx: cand[lane_sel[l]].rob_idx,
                       value:   cand[lane_sel[l]].value};
        end
      end
      for (int k = 0; k < FU_NUM; k++) begin
        if (accept[k] && !bypass_hit[k]) begin
          hold_v_d[k] = 1'b1;
          hold_q_d[k] = in_pay[k];
        end else if (grant[k]) begin
          hold_v_d[k] = 1'b0;
        end
      end
      if (|grant) rr_ptr_d = fu_next(last_idx);
    end
  end

  // State registers; synchronous reset is folded into the next-state logic.
  always_ff @(posedge clock) begin
    hold_v <= hold_v_d;
    hold_q <= hold_q_d;
    rr_ptr <= rr_ptr_d;
    cdb_q  <= cdb_d;
  end

  // Unpack registered lanes onto the broadcast ports.
  always_comb begin
    for (int l = 0; l < CDB_WIDTH; l++) begin
      cdb_valid_o[l]   = cdb_q[l].valid;
      cdb_tag_o[l]     = cdb_q[l].tag;
      cdb_rob_idx_o[l] = cdb_q[l].rob_idx;
      cdb_value_o[l]   = cdb_q[l].value;
    end
  end

endmodule
